// File: rtl/morse_pkg.sv
// Shared definitions for the Morse pulse emitter: FSM states, symbol encoding, letter limits.
// The TAIL state exists only when MORSE_EMIT_LETTER_GAP_EN is defined.
package morse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MARK = 3'd1,
      ST_GAP  = 3'd2,
`ifdef MORSE_EMIT_LETTER_GAP_EN
      ST_TAIL = 3'd3,
`endif
      ST_DONE = 3'd4
   } state_t;

   localparam logic SYM_DOT  = 1'b0;
   localparam logic SYM_DASH = 1'b1;

   localparam int MAX_SYMBOLS      = 4;
   localparam int LETTER_GAP_UNITS = 3;

endpackage

// File: rtl/morse_unit_timer.sv
// Duration timer: a 0..TICK_DIV-1 cycle prescaler feeding a unit down-counter.
// expire_o flags the last cycle of the last loaded unit.
module morse_unit_timer #(
   parameter int TICK_DIV  = 25_000_000,
   parameter int MAX_UNITS = 3,
   parameter int UNIT_W    = $clog2(MAX_UNITS + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [UNIT_W-1:0] units_i,
   output logic              expire_o
);

   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc;
   logic [UNIT_W-1:0]  unit_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         presc    <= '0;
         unit_cnt <= '0;
      end else if (load_i) begin
         presc    <= '0;
         unit_cnt <= units_i;
      end else if (presc == PRESC_LAST) begin
         // the unit count holds at zero so an idle timer never wraps
         presc <= '0;
         if (unit_cnt != '0)
            unit_cnt <= unit_cnt - UNIT_W'(1);
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   assign expire_o = (presc == PRESC_LAST) && (unit_cnt == UNIT_W'(1));

endmodule

// File: rtl/morse_pulse_emitter.sv
// Emits one Morse letter (up to 4 symbols, LSB first) on led_o as timed marks and gaps.
// Define MORSE_EMIT_LETTER_GAP_EN to append a 3-unit inter-letter gap (TAIL) before DONE.
module morse_pulse_emitter
   import morse_pkg::*;
#(
   parameter int TICK_DIV   = 25_000_000,
   parameter int DOT_UNITS  = 1,
   parameter int DASH_UNITS = 3,
   parameter int GAP_UNITS  = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] code_i,
   input  logic [2:0] len_i,
   output logic       led_o,
   output logic       busy_o,
   output logic       done_o
);

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

`ifdef MORSE_EMIT_LETTER_GAP_EN
   localparam int MAX_UNITS = max_int(max_int(DOT_UNITS, DASH_UNITS),
                                      max_int(GAP_UNITS, LETTER_GAP_UNITS));
`else
   localparam int MAX_UNITS = max_int(max_int(DOT_UNITS, DASH_UNITS), GAP_UNITS);
`endif
   localparam int UNIT_W = $clog2(MAX_UNITS + 1);

   function automatic logic [UNIT_W-1:0] mark_units(input logic sym);
      logic [UNIT_W-1:0] u;
      case (sym)
         SYM_DOT:  u = UNIT_W'(DOT_UNITS);
         SYM_DASH: u = UNIT_W'(DASH_UNITS);
         default:  u = UNIT_W'(DOT_UNITS);
      endcase
      return u;
   endfunction

   state_t            state, state_next;
   logic [3:0]        sym_sr;
   logic [2:0]        remaining;
   logic [2:0]        len_clamped;
   logic              capture, shift;
   logic              tmr_clear, tmr_load, tmr_expire;
   logic [UNIT_W-1:0] tmr_units;

   assign len_clamped = (len_i > 3'(MAX_SYMBOLS)) ? 3'(MAX_SYMBOLS) : len_i;

   morse_unit_timer #(
      .TICK_DIV  (TICK_DIV),
      .MAX_UNITS (MAX_UNITS),
      .UNIT_W    (UNIT_W)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (tmr_clear),
      .load_i   (tmr_load),
      .units_i  (tmr_units),
      .expire_o (tmr_expire)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      shift      = 1'b0;
      tmr_clear  = 1'b0;
      tmr_load   = 1'b0;
      tmr_units  = '0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               capture = 1'b1;
               if (len_clamped == 3'd0) begin
                  state_next = ST_DONE;
                  tmr_clear  = 1'b1;
               end else begin
                  state_next = ST_MARK;
                  tmr_load   = 1'b1;
                  tmr_units  = mark_units(code_i[0]);
               end
            end else begin
               tmr_clear = 1'b1;
            end
         end
         ST_MARK: begin
            if (tmr_expire) begin
               shift = 1'b1;
               if (remaining > 3'd1) begin
                  state_next = ST_GAP;
                  tmr_load   = 1'b1;
                  tmr_units  = UNIT_W'(GAP_UNITS);
               end else begin
`ifdef MORSE_EMIT_LETTER_GAP_EN
                  state_next = ST_TAIL;
                  tmr_load   = 1'b1;
                  tmr_units  = UNIT_W'(LETTER_GAP_UNITS);
`else
                  state_next = ST_DONE;
                  tmr_clear  = 1'b1;
`endif
               end
            end
         end
         ST_GAP: begin
            // the register was shifted on leaving MARK, so bit0 is the next symbol
            if (tmr_expire) begin
               state_next = ST_MARK;
               tmr_load   = 1'b1;
               tmr_units  = mark_units(sym_sr[0]);
            end
         end
`ifdef MORSE_EMIT_LETTER_GAP_EN
         ST_TAIL: begin
            if (tmr_expire) begin
               state_next = ST_DONE;
               tmr_clear  = 1'b1;
            end
         end
`endif
         ST_DONE: begin
            state_next = ST_IDLE;
            tmr_clear  = 1'b1;
         end
         default: begin
            state_next = ST_IDLE;
            tmr_clear  = 1'b1;
         end
      endcase
   end

   // outputs are registered from the next state so they line up with the state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sym_sr    <= '0;
         remaining <= '0;
         led_o     <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         if (capture) begin
            sym_sr    <= code_i;
            remaining <= len_clamped;
         end else if (shift) begin
            sym_sr    <= sym_sr >> 1;
            remaining <= remaining - 3'd1;
         end
         led_o  <= (state_next == ST_MARK);
         busy_o <= (state_next != ST_IDLE);
         done_o <= (state_next == ST_DONE);
      end
   end

endmodule

// File: tb/tb_morse_pulse_emitter.sv
// Directed bench for morse_pulse_emitter at TICK_DIV = 4; traces are captured as per-cycle bit vectors.
module tb_morse_pulse_emitter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] code = 4'd0;
   logic [2:0] len = 3'd0;
   logic       led, busy, done;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   logic [63:0] led_v, busy_v, done_v;

`ifdef MORSE_EMIT_LETTER_GAP_EN
   localparam int TAIL_CYC = 12;
`else
   localparam int TAIL_CYC = 0;
`endif

   morse_pulse_emitter #(.TICK_DIV(4)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .code_i  (code),
      .len_i   (len),
      .led_o   (led),
      .busy_o  (busy),
      .done_o  (done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] span(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] bit_at(input int i);
      logic [63:0] m = '0;
      m[i] = 1'b1;
      return m;
   endfunction

   task automatic clear_trace();
      led_v = '0; busy_v = '0; done_v = '0;
   endtask

   // inputs set before tick(c) belong to cycle c; outputs of cycle c+1 are recorded
   task automatic tick(input int c);
      @(posedge clk);
      #1;
      led_v[c+1]  = led;
      busy_v[c+1] = busy;
      done_v[c+1] = done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      assert_cnt++;
      if (led !== 1'b0) begin fail_cnt++; $display("FAIL reset_led: got %b expected 0", led); end
      assert_cnt++;
      if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
      assert_cnt++;
      if (done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done: got %b expected 0", done); end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_letter_a();
      logic [63:0] e_led, e_busy, e_done;
      clear_trace();
      for (int c = 0; c < 63; c++) begin
         start = (c == 0); code = 4'b0010; len = 3'd2;
         tick(c);
      end
      e_led  = span(1, 4) | span(9, 20);
      e_busy = span(1, 21 + TAIL_CYC);
      e_done = bit_at(21 + TAIL_CYC);
      assert_cnt++;
      if (led_v !== e_led) begin fail_cnt++; $display("FAIL a_led: got %h expected %h", led_v, e_led); end
      assert_cnt++;
      if (busy_v !== e_busy) begin fail_cnt++; $display("FAIL a_busy: got %h expected %h", busy_v, e_busy); end
      assert_cnt++;
      if (done_v !== e_done) begin fail_cnt++; $display("FAIL a_done: got %h expected %h", done_v, e_done); end
   endtask

   task automatic test_letter_e();
      logic [63:0] e_led, e_busy, e_done;
      clear_trace();
      for (int c = 0; c < 63; c++) begin
         start = (c == 0); code = 4'b0000; len = 3'd1;
         tick(c);
      end
      e_led  = span(1, 4);
      e_busy = span(1, 5 + TAIL_CYC);
      e_done = bit_at(5 + TAIL_CYC);
      assert_cnt++;
      if (led_v !== e_led) begin fail_cnt++; $display("FAIL e_led: got %h expected %h", led_v, e_led); end
      assert_cnt++;
      if (busy_v !== e_busy) begin fail_cnt++; $display("FAIL e_busy: got %h expected %h", busy_v, e_busy); end
      assert_cnt++;
      if (done_v !== e_done) begin fail_cnt++; $display("FAIL e_done: got %h expected %h", done_v, e_done); end
   endtask

   task automatic test_len_zero();
      clear_trace();
      for (int c = 0; c < 63; c++) begin
         start = (c == 0); code = 4'b0101; len = 3'd0;
         tick(c);
      end
      assert_cnt++;
      if (led_v !== 64'd0) begin fail_cnt++; $display("FAIL len0_led: got %h expected 0", led_v); end
      assert_cnt++;
      if (busy_v !== bit_at(1)) begin fail_cnt++; $display("FAIL len0_busy: got %h expected %h", busy_v, bit_at(1)); end
      assert_cnt++;
      if (done_v !== bit_at(1)) begin fail_cnt++; $display("FAIL len0_done: got %h expected %h", done_v, bit_at(1)); end
   endtask

   task automatic test_len_clamp();
      logic [63:0] e_led, e_busy, e_done;
      clear_trace();
      for (int c = 0; c < 63; c++) begin
         start = (c == 0); code = 4'b0101; len = 3'd7;
         tick(c);
      end
      e_led  = span(1, 12) | span(17, 20) | span(25, 36) | span(41, 44);
      e_busy = span(1, 45 + TAIL_CYC);
      e_done = bit_at(45 + TAIL_CYC);
      assert_cnt++;
      if (led_v !== e_led) begin fail_cnt++; $display("FAIL len7_led: got %h expected %h", led_v, e_led); end
      assert_cnt++;
      if (busy_v !== e_busy) begin fail_cnt++; $display("FAIL len7_busy: got %h expected %h", busy_v, e_busy); end
      assert_cnt++;
      if (done_v !== e_done) begin fail_cnt++; $display("FAIL len7_done: got %h expected %h", done_v, e_done); end
   endtask

   task automatic test_start_ignored();
      logic [63:0] e_led, e_busy, e_done;
      clear_trace();
      for (int c = 0; c < 63; c++) begin
         if (c == 0) begin start = 1'b1; code = 4'b0010; len = 3'd2; end
         else if (c == 2) begin start = 1'b1; code = 4'b1111; len = 3'd4; end
         else start = 1'b0;
         tick(c);
      end
      e_led  = span(1, 4) | span(9, 20);
      e_busy = span(1, 21 + TAIL_CYC);
      e_done = bit_at(21 + TAIL_CYC);
      assert_cnt++;
      if (led_v !== e_led) begin fail_cnt++; $display("FAIL ign_led: got %h expected %h", led_v, e_led); end
      assert_cnt++;
      if (busy_v !== e_busy) begin fail_cnt++; $display("FAIL ign_busy: got %h expected %h", busy_v, e_busy); end
      assert_cnt++;
      if (done_v !== e_done) begin fail_cnt++; $display("FAIL ign_done: got %h expected %h", done_v, e_done); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] e_led, e_busy, e_done;
      clear_trace();
      for (int c = 0; c < 63; c++) begin
         rst = (c == 10);
         if (c == 0) begin start = 1'b1; code = 4'b0101; len = 3'd4; end
         else if (c == 13) begin start = 1'b1; code = 4'b0001; len = 3'd1; end
         else start = 1'b0;
         tick(c);
      end
      rst = 1'b0;
      e_led  = span(1, 10) | span(14, 25);
      e_busy = span(1, 10) | span(14, 26 + TAIL_CYC);
      e_done = bit_at(26 + TAIL_CYC);
      assert_cnt++;
      if (led_v !== e_led) begin fail_cnt++; $display("FAIL rstmid_led: got %h expected %h", led_v, e_led); end
      assert_cnt++;
      if (busy_v !== e_busy) begin fail_cnt++; $display("FAIL rstmid_busy: got %h expected %h", busy_v, e_busy); end
      assert_cnt++;
      if (done_v !== e_done) begin fail_cnt++; $display("FAIL rstmid_done: got %h expected %h", done_v, e_done); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] e_led, e_busy, e_done;
      int          second;
      second = 7 + TAIL_CYC;
      clear_trace();
      for (int c = 0; c < 63; c++) begin
         start = (c < second); code = 4'b0000; len = 3'd1;
         tick(c);
      end
      e_led  = span(1, 4) | span(second, second + 3);
      e_busy = span(1, 5 + TAIL_CYC) | span(second, second + 4 + TAIL_CYC);
      e_done = bit_at(5 + TAIL_CYC) | bit_at(second + 4 + TAIL_CYC);
      assert_cnt++;
      if (led_v !== e_led) begin fail_cnt++; $display("FAIL b2b_led: got %h expected %h", led_v, e_led); end
      assert_cnt++;
      if (busy_v !== e_busy) begin fail_cnt++; $display("FAIL b2b_busy: got %h expected %h", busy_v, e_busy); end
      assert_cnt++;
      if (done_v !== e_done) begin fail_cnt++; $display("FAIL b2b_done: got %h expected %h", done_v, e_done); end
   endtask

   initial begin
      test_reset();
      test_letter_a();
      test_letter_e();
      test_len_zero();
      test_len_clamp();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/morse_pulse_emitter.md
# morse_pulse_emitter

Sequential stage directly downstream of the Morse letter selector. Takes a latched Morse pattern (up to 4 symbols, dot=0 / dash=1, LSB sent first) plus its symbol count, and on a start pulse drives the LED as timed dot/dash marks separated by fixed gaps. Reports busy while emitting and pulses done when the letter is complete. Sits between the letter selector and the board LED.

## Interface
- TICK_DIV, 25_000_000: clock cycles per Morse time unit (0.5 s at 50 MHz); must be ≥ 2.
- DOT_UNITS, 1: mark length of a dot, in units.
- DASH_UNITS, 3: mark length of a dash, in units.
- GAP_UNITS, 1: intra-letter gap between symbols, in units.
- clk_i  input  1  system clock; single clock domain.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle request; sampled only in IDLE.
- code_i  input  4  symbol pattern; bit0 = first symbol; 0 = dot, 1 = dash.
- len_i  input  3  symbol count, 0..4; values 5..7 are clamped to 4.
- led_o  output  1  Morse output; 1 during a mark.
- busy_o  output  1  high from the cycle after start is accepted until done_o.
- done_o  output  1  one-cycle pulse at end of letter.

## Operation
- States: IDLE, MARK, GAP, TAIL (only with macro), DONE.
- Reset (sync, any state): state = IDLE; led_o = 0, busy_o = 0, done_o = 0; all counters and shift register are 0.
- IDLE: when start_i = 1, capture code_i into a 4-bit shift register and min(len_i, 4) into a remaining-symbol counter.
  - If the count is 0, go to DONE.
  - Otherwise, go to MARK with duration DOT_UNITS or DASH_UNITS from bit0.
- MARK: led_o = 1. When the duration expires, decrement the remaining count and shift the register right. Go to GAP if symbols remain; otherwise go to TAIL (macro on) or DONE.
- GAP: led_o = 0 for GAP_UNITS. Then go to MARK with the duration taken from the new bit0.
- DONE: lasts one cycle. done_o = 1, busy_o = 1, led_o = 0. Then go to IDLE.
- code_i, len_i and start_i are ignored outside IDLE. A start_i held high re-triggers on the cycle after DONE.
- Duration counting: a cycle prescaler 0..TICK_DIV−1 plus a unit counter. Both clear on every state entry. Expiry occurs on the last cycle of the last unit.
- Width rules:
  - Prescaler width = $clog2(TICK_DIV).
  - Unit counter width = $clog2(max unit count + 1).
  - No wrap inside a state.

## Timing
- Outputs are registered, derived from state.
- Start accepted on the edge ending cycle k: busy_o = 1 and led_o = 1 from cycle k+1.
- Dot mark = DOT_UNITS·TICK_DIV cycles. Dash mark = DASH_UNITS·TICK_DIV cycles. Gap = GAP_UNITS·TICK_DIV cycles.
- len 0: done_o in cycle k+1, led_o never rises.
- done_o is asserted in the cycle immediately following the final mark (or the TAIL).
- Reset asserted mid-letter: led_o = 0 on the next cycle, and no done_o is produced.

## Configuration
- MORSE_EMIT_LETTER_GAP_EN defined:
  - After the final mark, enter TAIL: led_o = 0, busy_o = 1 for 3 units (inter-letter gap).
  - Then go to DONE.
  - Back-to-back letters are therefore correctly spaced.
- Undefined: TAIL state and its logic are absent; the final MARK goes straight to DONE.

## Structure
- Shared package morse_pkg:
  - State enum typedef.
  - Symbol encoding constants (SYM_DOT = 0, SYM_DASH = 1).
  - MAX_SYMBOLS = 4.
  - LETTER_GAP_UNITS = 3.
- Sub-module morse_unit_timer: prescaler plus unit counter, with inputs clear/load-units and output expire. It is instantiated once.

## Test plan
- All scenarios use TICK_DIV = 4 and default units.
- A (code 0010, len 2), start in cycle 0:
  - led_o = 1 in cycles 1–4, 0 in 5–8, 1 in 9–20.
  - done_o in cycle 21 (macro off) or cycle 33 (macro on).
  - busy_o = 1 in cycles 1–21 (or 1–33).
- E (code 0000, len 1): led_o = 1 in cycles 1–4; done_o in cycle 5.
- len_i = 0 and len_i = 7 with code 0101:
  - len 0: done_o in cycle 1, led_o stays 0.
  - len 7: emitted as 4 symbols — dash, dot, dash, dot; total marks 12+4+12+4 cycles, with 4-cycle gaps.
- start_i pulsed with code 1111 during the MARK of a letter A: ignored; output identical to the lone-A trace.
- rst_i for 1 cycle during cycle 10 of a letter C: led_o = 0 and busy_o = 0 from cycle 11; no done_o. A new start in cycle 13 emits a correct dash from cycle 14.
